// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-store FIFO draining oldest-first to memory, with
// same-cycle load search that forwards from word stores or stalls on partial ones.
module store_write_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_WIDTH-1:0]      st_addr,
  input  logic [DATA_WIDTH-1:0]      st_data,
  input  logic [2:0]                 st_mode,
  input  logic                       ld_valid,
  input  logic [ADDR_WIDTH-1:0]      ld_addr,
  input  logic [2:0]                 ld_mode,
  output logic                       ld_fwd_hit,
  output logic [DATA_WIDTH-1:0]      ld_fwd_data,
  output logic                       ld_stall,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wd,
  output logic [2:0]                 mem_mode,
  input  logic                       mem_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [2:0]            mode_q [DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d, sel;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop, found, is_word;
  logic [DATA_WIDTH-1:0] w, sh_b, sh_h, ext;
  assign count    = count_q;
  assign empty    = count_q == '0;
  assign st_ready = count_q != CW'(DEPTH);
  assign mem_we   = !empty;
  assign mem_addr = mem_we ? addr_q[head_q] : '0;
  assign mem_wd   = mem_we ? data_q[head_q] : '0;
  assign mem_mode = mem_we ? mode_q[head_q] : '0;
  assign push     = st_valid && st_ready && st_mode <= 3'b010;
  assign pop      = mem_we && mem_ready;
  always_comb begin
    head_d  = pop ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        addr_q[tail_q] <= st_addr;
        data_q[tail_q] <= st_data;
        mode_q[tail_q] <= st_mode;
      end
    end
  end
  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    found = 1'b0;
    sel   = head_q;
    for (int i = 0; i < DEPTH; i++)
      if (i < int'(count_q) && addr_q[head_q + PW'(i)][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]) begin
        found = 1'b1;
        sel   = head_q + PW'(i);
      end
  end
  assign w       = data_q[sel];
  assign is_word = mode_q[sel] == 3'b010;
  assign sh_b    = w >> {ld_addr[1:0], 3'b000};
  assign sh_h    = w >> {ld_addr[1], 4'b0000};
  assign ext = ld_mode == 3'b000 ? {{(DATA_WIDTH-8){sh_b[7]}}, sh_b[7:0]} :
               ld_mode == 3'b001 ? {{(DATA_WIDTH-16){sh_h[15]}}, sh_h[15:0]} :
               ld_mode == 3'b010 ? w :
               ld_mode == 3'b100 ? DATA_WIDTH'(sh_b[7:0]) :
               ld_mode == 3'b101 ? DATA_WIDTH'(sh_h[15:0]) : '0;
  assign ld_fwd_hit  = ld_valid && found && is_word;
  assign ld_stall    = ld_valid && found && !is_word;
  assign ld_fwd_data = ld_fwd_hit ? ext : '0;
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed stimulus queues expected values per cycle;
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_store_write_buffer;
  logic        clk = 1'b0;
  logic        rst_n, st_valid, st_ready, ld_valid, ld_fwd_hit, ld_stall;
  logic        mem_we, mem_ready, empty;
  logic [31:0] st_addr, st_data, ld_addr, ld_fwd_data, mem_addr, mem_wd;
  logic [2:0]  st_mode, ld_mode, mem_mode;
  logic [2:0]  count;
  int          cyc_n = 0;
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    string       name;
    int          cyc;
    int          sig;
    logic [31:0] exp;
  } item_t;
  item_t q[$];
  localparam int S_CNT = 0, S_RDY = 1, S_WE = 2, S_MADDR = 3, S_HIT = 4,
                 S_STALL = 5, S_FDATA = 6, S_EMPTY = 7, S_WD = 8, S_MMODE = 9;
  store_write_buffer dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_mode(st_mode),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_mode(ld_mode),
    .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data), .ld_stall(ld_stall),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_mode(mem_mode),
    .mem_ready(mem_ready), .count(count), .empty(empty)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  function automatic logic [31:0] actual(int sig);
    case (sig)
      S_CNT:   return 32'(count);
      S_RDY:   return 32'(st_ready);
      S_WE:    return 32'(mem_we);
      S_MADDR: return mem_addr;
      S_HIT:   return 32'(ld_fwd_hit);
      S_STALL: return 32'(ld_stall);
      S_FDATA: return ld_fwd_data;
      S_EMPTY: return 32'(empty);
      S_WD:    return mem_wd;
      default: return 32'(mem_mode);
    endcase
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc_n) begin
      item_t it;
      logic [31:0] a;
      it = q.pop_front();
      a = actual(it.sig);
      checks++;
      if (a !== it.exp) begin
        errors++;
        $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", it.name, it.cyc, a, it.exp);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    st_valid = 0; st_addr = 0; st_data = 0; st_mode = 0;
    ld_valid = 0; ld_addr = 0; ld_mode = 0; mem_ready = 0;
  endtask
  task automatic chk(string name, int sig, logic [31:0] exp);
    q.push_back('{name, cyc_n, sig, exp});
  endtask
  task automatic st(logic [31:0] a, logic [31:0] d, logic [2:0] m);
    st_valid = 1; st_addr = a; st_data = d; st_mode = m;
  endtask
  task automatic ld(logic [31:0] a, logic [2:0] m);
    ld_valid = 1; ld_addr = a; ld_mode = m;
  endtask
  task automatic chk_ld(string name, logic h, logic s, logic [31:0] d);
    chk({name, "_hit"}, S_HIT, 32'(h));
    chk({name, "_stall"}, S_STALL, 32'(s));
    chk({name, "_data"}, S_FDATA, d);
  endtask
  initial begin
    rst_n = 0;
    tick();
    tick();
    chk("rst_count", S_CNT, 0); chk("rst_empty", S_EMPTY, 1); chk("rst_ready", S_RDY, 1);
    chk("rst_we", S_WE, 0); chk("rst_maddr", S_MADDR, 0); chk("rst_wd", S_WD, 0);
    ld(32'h100, 3'b010); chk_ld("rst_ld", 0, 0, 0);
    rst_n = 1;
    // fill four entries with memory stalled
    tick(); st(32'h100, 32'h1100, 3'b010);
    tick(); st(32'h104, 32'h1104, 3'b010); chk("fill_c1", S_CNT, 1); chk("fill_head", S_MADDR, 32'h100);
    tick(); st(32'h108, 32'h1108, 3'b010); chk("fill_c2", S_CNT, 2);
    tick(); st(32'h10C, 32'h110C, 3'b010); chk("fill_c3", S_CNT, 3);
    tick(); st(32'h110, 32'h1110, 3'b010); chk("full_c4", S_CNT, 4); chk("full_rdy", S_RDY, 0);
    tick(); chk("no_5th", S_CNT, 4); chk("head_held", S_MADDR, 32'h100); chk("head_wd", S_WD, 32'h1100);
    // drain, with one push+pop at count 2
    tick(); mem_ready = 1; chk("drain0", S_MADDR, 32'h100);
    tick(); mem_ready = 1; chk("drain1", S_MADDR, 32'h104); chk("drain1_c", S_CNT, 3);
    tick(); mem_ready = 1; st(32'h120, 32'h1120, 3'b010); chk("drain2", S_MADDR, 32'h108); chk("pp_before", S_CNT, 2);
    tick(); mem_ready = 1; chk("drain3", S_MADDR, 32'h10C); chk("pp_after", S_CNT, 2);
    tick(); mem_ready = 1; chk("drain4", S_MADDR, 32'h120); chk("drain4_c", S_CNT, 1);
    tick(); chk("drained_empty", S_EMPTY, 1); chk("drained_we", S_WE, 0);
    // forwarding with extraction and extension
    tick(); st(32'h200, 32'h8000_00F0, 3'b010);
    tick(); ld(32'h200, 3'b010); chk_ld("fwd_lw", 1, 0, 32'h8000_00F0);
    tick(); ld(32'h200, 3'b000); chk_ld("fwd_lb", 1, 0, 32'hFFFF_FFF0);
    tick(); ld(32'h203, 3'b100); chk_ld("fwd_lbu", 1, 0, 32'h0000_0080);
    tick(); ld(32'h202, 3'b101); chk_ld("fwd_lhu", 1, 0, 32'h0000_8000);
    tick(); ld(32'h202, 3'b001); chk_ld("fwd_lh", 1, 0, 32'hFFFF_8000);
    tick(); ld(32'h204, 3'b010); chk_ld("fwd_miss", 0, 0, 0);
    tick(); mem_ready = 1;
    // youngest match wins
    tick(); st(32'h300, 32'h1111_1111, 3'b010);
    tick(); st(32'h300, 32'h2222_2222, 3'b010);
    tick(); mem_ready = 1; ld(32'h300, 3'b010); chk_ld("young2", 1, 0, 32'h2222_2222);
    tick(); mem_ready = 1; ld(32'h300, 3'b010); chk_ld("young1", 1, 0, 32'h2222_2222); chk("young1_c", S_CNT, 1);
    tick(); ld(32'h300, 3'b010); chk_ld("young0", 0, 0, 0); chk("young0_c", S_CNT, 0);
    // partial store conflict stalls until drained
    tick(); st(32'h400, 32'hAABB_CCDD, 3'b010);
    tick(); st(32'h401, 32'h0000_0055, 3'b000);
    tick(); mem_ready = 1; ld(32'h400, 3'b010); chk_ld("stall2", 0, 1, 0);
    tick(); mem_ready = 1; ld(32'h400, 3'b010); chk_ld("stall1", 0, 1, 0); chk("byte_mode", S_MMODE, 0); chk("byte_wd", S_WD, 32'h55);
    tick(); ld(32'h400, 3'b010); chk_ld("stall0", 0, 0, 0); chk("stall0_e", S_EMPTY, 1);
    // younger word shadows older byte; illegal store mode ignored
    tick(); st(32'h500, 32'h0000_0077, 3'b000);
    tick(); st(32'h500, 32'h1234_5678, 3'b010);
    tick(); ld(32'h501, 3'b100); chk_ld("shadow_lbu", 1, 0, 32'h56);
    tick(); ld(32'h502, 3'b001); chk_ld("shadow_lh", 1, 0, 32'h1234); st(32'h600, 32'h1, 3'b011);
    tick(); mem_ready = 1; chk("bad_mode", S_CNT, 2);
    tick(); mem_ready = 1;
    // reset mid-operation with mem_ready high
    tick(); st(32'h700, 32'h7, 3'b010);
    tick(); st(32'h704, 32'h7, 3'b010);
    tick(); st(32'h708, 32'h7, 3'b010);
    tick(); chk("pre_rst_c", S_CNT, 3); ld(32'h704, 3'b010); chk_ld("pre_rst", 1, 0, 32'h7);
    rst_n = 0; mem_ready = 1;
    tick(); rst_n = 1; chk("mid_rst_c", S_CNT, 0); chk("mid_rst_we", S_WE, 0);
    ld(32'h704, 3'b010); chk_ld("mid_rst_ld", 0, 0, 0);
    tick(); ld(32'h708, 3'b000); chk_ld("mid_rst_ld2", 0, 0, 0); chk("mid_rst_maddr", S_MADDR, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain_queue: %0d items left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
